// File: rtl/alu_sequencer.sv
// Sequences multi-iteration commands through an external combinational ALU.
// Each iteration is EXEC (ALU evaluates, result captured) then WB (accumulator loaded).
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_operand,
    input  logic [3:0]  cmd_count,
    input  logic        cmd_stop_z,
    input  logic        z_clear,
    output logic [2:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_r,
    input  logic [15:0] alu_result,
    output logic [15:0] acc,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_ILL = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] operand_q, operand_d;
    logic [3:0]  count_q, count_d;
    logic        stop_z_q, stop_z_d;
    logic [3:0]  iter_q, iter_d;
    logic [15:0] res_q, res_d;
    logic [15:0] acc_q, acc_d;
    logic        z_q, z_d;
    logic        z_set_s;
    logic        abort_s;
    logic        last_s;

    // An early abort only happens on a zero SUB result with stop_z armed.
    assign abort_s = (op_q == OP_SUB) && stop_z_q && (res_q == 16'h0000);
    assign last_s  = abort_s || (iter_q == count_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: command latch, result capture, accumulator and zero flag.
    always_comb begin
        op_d      = op_q;
        operand_d = operand_q;
        count_d   = count_q;
        stop_z_d  = stop_z_q;
        iter_d    = iter_q;
        res_d     = res_q;
        acc_d     = acc_q;
        z_set_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d      = cmd_op;
                    operand_d = cmd_operand;
                    count_d   = cmd_count;
                    stop_z_d  = cmd_stop_z;
                    iter_d    = 4'd0;
                end else begin
                    iter_d    = iter_q;
                end
            end
            ST_EXEC: res_d = alu_result;
            ST_WB: begin
                if (op_q != OP_ILL) begin
                    acc_d = res_q;
                end else begin
                    acc_d = acc_q;
                end
                iter_d  = iter_q + 4'd1;
                z_set_s = (op_q == OP_SUB) && (res_q == 16'h0000);
            end
            default: res_d = res_q;
        endcase
        // A clear request takes priority over a simultaneous set.
        if (z_clear) begin
            z_d = 1'b0;
        end else if (z_set_s) begin
            z_d = 1'b1;
        end else begin
            z_d = z_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 3'b000;
            operand_q <= 16'h0000;
            count_q   <= 4'd0;
            stop_z_q  <= 1'b0;
            iter_q    <= 4'd0;
            res_q     <= 16'h0000;
            acc_q     <= 16'h0000;
            z_q       <= 1'b0;
        end else begin
            op_q      <= op_d;
            operand_q <= operand_d;
            count_q   <= count_d;
            stop_z_q  <= stop_z_d;
            iter_q    <= iter_d;
            res_q     <= res_d;
            acc_q     <= acc_d;
            z_q       <= z_d;
        end
    end

    // Output decode.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        if ((state_q == ST_EXEC) && (op_q != OP_ILL)) begin
            alu_ctrl = op_q;
        end else begin
            alu_ctrl = 3'b000;
        end
        done  = (state_q == ST_WB) && last_s;
        err   = done && (op_q == OP_ILL);
        alu_a = acc_q;
        alu_r = operand_q;
        acc   = acc_q;
        z     = z_q;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and randomized bench for alu_sequencer with a behavioural ALU and command model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_operand;
    logic [3:0]  cmd_count;
    logic        cmd_stop_z;
    logic        z_clear;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_r;
    logic [15:0] alu_result;
    logic [15:0] acc;
    logic        z;
    logic        busy;
    logic        done;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_acc = 16'h0000;
    logic        m_z   = 1'b0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_count(cmd_count),
        .cmd_stop_z(cmd_stop_z), .z_clear(z_clear), .alu_ctrl(alu_ctrl),
        .alu_a(alu_a), .alu_r(alu_r), .alu_result(alu_result), .acc(acc),
        .z(z), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] r);
        case (op)
            3'd1:    return a | r;
            3'd2:    return a - r;
            3'd3:    return a << r;
            3'd4:    return a >> r;
            3'd5:    return r;
            3'd6:    return a + 16'd1;
            default: return a;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_r);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command from IDLE (#1 after an edge) and checks it cycle by cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] opr, input logic [3:0] cnt,
                           input logic sz, input logic zclr);
        logic [15:0] a;
        logic [15:0] r;
        logic        zm;
        logic        last;
        int          n;
        int          pulses;
        a = m_acc;
        zm = m_z;
        n = 0;
        for (int i = 0; i <= int'(cnt); i++) begin
            r = alu_fn(op, a, opr);
            n++;
            if (op != 3'd7) a = r;
            last = (i == int'(cnt)) || (op == 3'd2 && sz && r == 16'h0000);
            if (last && zclr) zm = 1'b0;
            else if (op == 3'd2 && r == 16'h0000) zm = 1'b1;
            if (last) break;
        end
        chk("ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = opr; cmd_count = cnt; cmd_stop_z = sz;
        @(posedge clk); #1;
        // Junk offered while busy must be ignored.
        cmd_op = 3'($urandom); cmd_operand = 16'($urandom); cmd_count = 4'($urandom);
        cmd_stop_z = 1'($urandom);
        chk("busy_exec", busy, 1'b1);
        chk("alu_ctrl_exec", alu_ctrl, (op == 3'd7) ? 3'd0 : op);
        pulses = 0;
        for (int k = 1; k <= 2 * n; k++) begin
            @(posedge clk); #1;
            z_clear = 1'b0;
            if (done) pulses++;
            chk("done_timing", done, k == 2 * n - 1);
            chk("err_timing", err, (k == 2 * n - 1) && (op == 3'd7));
            if (k % 2 == 0 && k < 2 * n) chk("alu_ctrl_iter", alu_ctrl, (op == 3'd7) ? 3'd0 : op);
            if (k == 2 * n - 1) begin
                cmd_valid = 1'b0;
                z_clear = zclr;
            end
        end
        chk("done_pulses", pulses, 1);
        chk("acc_result", acc, a);
        chk("z_result", z, zm);
        chk("ready_after", cmd_ready, 1'b1);
        chk("alu_a_eq_acc", alu_a, a);
        m_acc = a;
        m_z = zm;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = 16'h0;
        cmd_count = 4'd0; cmd_stop_z = 1'b0; z_clear = 1'b0;
        #12;
        chk("rst_acc", acc, 16'h0);
        chk("rst_z", z, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_alu_ctrl", alu_ctrl, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 1'b1);

        run_cmd(3'd5, 16'h0005, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd2, 16'h0005, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd5, 16'h0001, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd3, 16'h0001, 4'd3, 1'b0, 1'b0);
        chk("lshift_0x10", acc, 16'h0010);
        run_cmd(3'd5, 16'h0003, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd2, 16'h0003, 4'd0, 1'b0, 1'b1);
        chk("zclear_wins", z, 1'b0);
        run_cmd(3'd5, 16'h0006, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd2, 16'h0002, 4'd7, 1'b1, 1'b0);
        chk("stopz_z", z, 1'b1);
        run_cmd(3'd5, 16'hFFFF, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd6, 16'h0000, 4'd0, 1'b0, 1'b0);
        chk("inc_wrap", acc, 16'h0000);
        run_cmd(3'd7, 16'h1234, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd4, 16'h0002, 4'd1, 1'b0, 1'b0);
        run_cmd(3'd1, 16'hA5A0, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd0, 16'h0F0F, 4'd2, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [2:0]  op;
            logic [15:0] opr;
            op = 3'($urandom_range(0, 7));
            opr = ($urandom_range(0, 3) == 0) ? m_acc : 16'($urandom);
            if (op == 3'd3 || op == 3'd4) opr = 16'($urandom_range(0, 17));
            run_cmd(op, opr, 4'($urandom_range(0, 4)), 1'($urandom),
                    $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a long command.
        run_cmd(3'd5, 16'h1234, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd2, 16'h1234, 4'd0, 1'b0, 1'b0);
        run_cmd(3'd5, 16'h00AB, 4'd0, 1'b0, 1'b0);
        chk("pre_rst_z", z, 1'b1);
        cmd_valid = 1'b1; cmd_op = 3'd6; cmd_operand = 16'h0; cmd_count = 4'd5; cmd_stop_z = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", acc, 16'h0);
        chk("mid_rst_z", z, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_ctrl", alu_ctrl, 3'd0);
        chk("mid_rst_alu_r", alu_r, 16'h0);
        @(posedge clk); #1;
        chk("rst_hold_done", done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_acc", acc, 16'h0);
        m_acc = 16'h0000;
        m_z = 1'b0;
        run_cmd(3'd6, 16'h0000, 4'd2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
